// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: pops receiver bytes, resolves E0/F0/E1 prefixes, tracks modifiers, emits key events.
// Optional typematic repeat suppression is enabled by defining KBD_REPEAT_FILTER_EN.
module ps2_scancode_decoder (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] kbd_data,
    input  logic       kbd_ready,
    output logic       kbd_nextdata_n,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic [7:0] ev_ascii,
    output logic       shift,
    output logic       ctrl,
    output logic       caps
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_POP    = 3'd1,
        S_WAIT   = 3'd2,
        S_DECODE = 3'd3,
        S_EMIT   = 3'd4
    } state_t;

    state_t      state_r, state_s;
    logic [7:0]  byte_r, byte_s;
    logic        ext_pend_r, ext_pend_s, brk_pend_r, brk_pend_s;
    logic [2:0]  skip_cnt_r, skip_s;
    logic        lshift_r, lshift_s, rshift_r, rshift_s;
    logic        lctrl_r, lctrl_s, rctrl_r, rctrl_s;
    logic        caps_r, caps_s, caps_held_r, caps_held_s;
    logic        shift_r, shift_s, ctrl_r, ctrl_s;
    logic        pop_n_r, pop_n_s;
    logic        ev_valid_r, ev_valid_s, ev_ext_r, ev_ext_s, ev_break_r, ev_break_s;
    logic [7:0]  ev_code_r, ev_code_s, ev_ascii_r, ev_ascii_s;
    logic [8:0]  key_s;
    logic        caps_hit_s;
    logic        is_repeat_s;
`ifdef KBD_REPEAT_FILTER_EN
    logic        rep_valid_r, rep_valid_s;
    logic [8:0]  rep_key_r, rep_key_s;
`endif

    // ASCII of a non-extended make; upper selects letter case, shifted selects digit-row symbols.
    function automatic logic [7:0] ascii_of(input logic [7:0] code, input logic upper, input logic shifted);
        logic [7:0] base;
        base = upper ? 8'h41 : 8'h61;
        case (code)
            8'h1C: ascii_of = base + 8'd0;
            8'h32: ascii_of = base + 8'd1;
            8'h21: ascii_of = base + 8'd2;
            8'h23: ascii_of = base + 8'd3;
            8'h24: ascii_of = base + 8'd4;
            8'h2B: ascii_of = base + 8'd5;
            8'h34: ascii_of = base + 8'd6;
            8'h33: ascii_of = base + 8'd7;
            8'h43: ascii_of = base + 8'd8;
            8'h3B: ascii_of = base + 8'd9;
            8'h42: ascii_of = base + 8'd10;
            8'h4B: ascii_of = base + 8'd11;
            8'h3A: ascii_of = base + 8'd12;
            8'h31: ascii_of = base + 8'd13;
            8'h44: ascii_of = base + 8'd14;
            8'h4D: ascii_of = base + 8'd15;
            8'h15: ascii_of = base + 8'd16;
            8'h2D: ascii_of = base + 8'd17;
            8'h1B: ascii_of = base + 8'd18;
            8'h2C: ascii_of = base + 8'd19;
            8'h3C: ascii_of = base + 8'd20;
            8'h2A: ascii_of = base + 8'd21;
            8'h1D: ascii_of = base + 8'd22;
            8'h22: ascii_of = base + 8'd23;
            8'h35: ascii_of = base + 8'd24;
            8'h1A: ascii_of = base + 8'd25;
            8'h45: ascii_of = shifted ? 8'h29 : 8'h30;
            8'h16: ascii_of = shifted ? 8'h21 : 8'h31;
            8'h1E: ascii_of = shifted ? 8'h40 : 8'h32;
            8'h26: ascii_of = shifted ? 8'h23 : 8'h33;
            8'h25: ascii_of = shifted ? 8'h24 : 8'h34;
            8'h2E: ascii_of = shifted ? 8'h25 : 8'h35;
            8'h36: ascii_of = shifted ? 8'h5E : 8'h36;
            8'h3D: ascii_of = shifted ? 8'h26 : 8'h37;
            8'h3E: ascii_of = shifted ? 8'h2A : 8'h38;
            8'h46: ascii_of = shifted ? 8'h28 : 8'h39;
            8'h29: ascii_of = 8'h20;
            8'h5A: ascii_of = 8'h0D;
            8'h66: ascii_of = 8'h08;
            8'h0D: ascii_of = 8'h09;
            8'h76: ascii_of = 8'h1B;
            default: ascii_of = 8'h00;
        endcase
    endfunction

    assign key_s      = {ext_pend_r, byte_r};
    assign caps_hit_s = ~ext_pend_r & (byte_r == 8'h58);
`ifdef KBD_REPEAT_FILTER_EN
    assign is_repeat_s = ~brk_pend_r & rep_valid_r & (rep_key_r == key_s);
`else
    assign is_repeat_s = 1'b0;
`endif

    // Next-state, prefix/modifier bookkeeping and next event outputs.
    always_comb begin
        state_s     = state_r;
        byte_s      = byte_r;
        ext_pend_s  = ext_pend_r;
        brk_pend_s  = brk_pend_r;
        skip_s      = skip_cnt_r;
        lshift_s    = lshift_r;
        rshift_s    = rshift_r;
        lctrl_s     = lctrl_r;
        rctrl_s     = rctrl_r;
        caps_s      = caps_r;
        caps_held_s = caps_held_r;
        pop_n_s     = 1'b1;
        ev_valid_s  = ev_valid_r;
        ev_code_s   = ev_code_r;
        ev_ext_s    = ev_ext_r;
        ev_break_s  = ev_break_r;
        ev_ascii_s  = ev_ascii_r;
`ifdef KBD_REPEAT_FILTER_EN
        rep_valid_s = rep_valid_r;
        rep_key_s   = rep_key_r;
`endif
        case (state_r)
            S_IDLE: begin
                if (kbd_ready && !ev_valid_r) begin
                    byte_s  = kbd_data;
                    pop_n_s = 1'b0;
                    state_s = S_POP;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_POP:  state_s = S_WAIT;
            // The receiver's ready/data are not trusted in the cycle right after the pop.
            S_WAIT: state_s = S_DECODE;
            S_DECODE: begin
                state_s = S_IDLE;
                if (skip_cnt_r != 3'd0) begin
                    skip_s = skip_cnt_r - 3'd1;
                end else if (byte_r == 8'hE0) begin
                    ext_pend_s = 1'b1;
                end else if (byte_r == 8'hF0) begin
                    brk_pend_s = 1'b1;
                end else if (byte_r == 8'hE1) begin
                    skip_s     = 3'd7;
                    ext_pend_s = 1'b0;
                    brk_pend_s = 1'b0;
                end else begin
                    ext_pend_s = 1'b0;
                    brk_pend_s = 1'b0;
                    if (is_repeat_s) begin
                        state_s = S_IDLE;
                    end else begin
                        state_s    = S_EMIT;
                        ev_valid_s = 1'b1;
                        ev_code_s  = byte_r;
                        ev_ext_s   = ext_pend_r;
                        ev_break_s = brk_pend_r;
                        // Translation uses modifier state from before this code.
                        ev_ascii_s = (ext_pend_r || brk_pend_r) ? 8'h00
                                   : ascii_of(byte_r, shift_r ^ caps_r, shift_r);
                        lshift_s    = (key_s == 9'h012) ? ~brk_pend_r : lshift_r;
                        rshift_s    = (key_s == 9'h059) ? ~brk_pend_r : rshift_r;
                        lctrl_s     = (key_s == 9'h014) ? ~brk_pend_r : lctrl_r;
                        rctrl_s     = (key_s == 9'h114) ? ~brk_pend_r : rctrl_r;
                        caps_s      = (caps_hit_s && !brk_pend_r && !caps_held_r) ? ~caps_r : caps_r;
                        caps_held_s = caps_hit_s ? ~brk_pend_r : caps_held_r;
`ifdef KBD_REPEAT_FILTER_EN
                        if (!brk_pend_r) begin
                            rep_valid_s = 1'b1;
                            rep_key_s   = key_s;
                        end else if (rep_key_r == key_s) begin
                            rep_valid_s = 1'b0;
                        end else begin
                            rep_valid_s = rep_valid_r;
                        end
`endif
                    end
                end
            end
            S_EMIT: begin
                if (ev_ready) begin
                    ev_valid_s = 1'b0;
                    state_s    = S_IDLE;
                end else begin
                    state_s = S_EMIT;
                end
            end
            default: state_s = S_IDLE;
        endcase
        shift_s = lshift_s | rshift_s;
        ctrl_s  = lctrl_s | rctrl_s;
    end

    // State and output registers, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!clrn) begin
            state_r     <= S_IDLE;
            byte_r      <= 8'h00;
            ext_pend_r  <= 1'b0;
            brk_pend_r  <= 1'b0;
            skip_cnt_r  <= 3'd0;
            lshift_r    <= 1'b0;
            rshift_r    <= 1'b0;
            lctrl_r     <= 1'b0;
            rctrl_r     <= 1'b0;
            caps_r      <= 1'b0;
            caps_held_r <= 1'b0;
            shift_r     <= 1'b0;
            ctrl_r      <= 1'b0;
            pop_n_r     <= 1'b1;
            ev_valid_r  <= 1'b0;
            ev_code_r   <= 8'h00;
            ev_ext_r    <= 1'b0;
            ev_break_r  <= 1'b0;
            ev_ascii_r  <= 8'h00;
`ifdef KBD_REPEAT_FILTER_EN
            rep_valid_r <= 1'b0;
            rep_key_r   <= 9'h000;
`endif
        end else begin
            state_r     <= state_s;
            byte_r      <= byte_s;
            ext_pend_r  <= ext_pend_s;
            brk_pend_r  <= brk_pend_s;
            skip_cnt_r  <= skip_s;
            lshift_r    <= lshift_s;
            rshift_r    <= rshift_s;
            lctrl_r     <= lctrl_s;
            rctrl_r     <= rctrl_s;
            caps_r      <= caps_s;
            caps_held_r <= caps_held_s;
            shift_r     <= shift_s;
            ctrl_r      <= ctrl_s;
            pop_n_r     <= pop_n_s;
            ev_valid_r  <= ev_valid_s;
            ev_code_r   <= ev_code_s;
            ev_ext_r    <= ev_ext_s;
            ev_break_r  <= ev_break_s;
            ev_ascii_r  <= ev_ascii_s;
`ifdef KBD_REPEAT_FILTER_EN
            rep_valid_r <= rep_valid_s;
            rep_key_r   <= rep_key_s;
`endif
        end
    end

    assign kbd_nextdata_n = pop_n_r;
    assign ev_valid       = ev_valid_r;
    assign ev_code        = ev_code_r;
    assign ev_ext         = ev_ext_r;
    assign ev_break       = ev_break_r;
    assign ev_ascii       = ev_ascii_r;
    assign shift          = shift_r;
    assign ctrl           = ctrl_r;
    assign caps           = caps_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: emulated receiver FIFO, key-state reference model, directed and random scenarios.
module tb_ps2_scancode_decoder;

    logic       clk = 1'b0;
    logic       clrn;
    logic [7:0] kbd_data = 8'h00;
    logic       kbd_ready = 1'b0;
    logic       kbd_nextdata_n;
    logic       ev_valid;
    logic       ev_ready;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic [7:0] ev_ascii;
    logic       shift;
    logic       ctrl;
    logic       caps;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [7:0] ascii;
        logic       sh;
    } ev_t;

    ev_t exp_q[$];
    ev_t got_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;

    ps2_scancode_decoder dut (
        .clk(clk), .clrn(clrn), .kbd_data(kbd_data), .kbd_ready(kbd_ready),
        .kbd_nextdata_n(kbd_nextdata_n), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_code(ev_code), .ev_ext(ev_ext), .ev_break(ev_break), .ev_ascii(ev_ascii),
        .shift(shift), .ctrl(ctrl), .caps(caps)
    );

    always #5 clk = ~clk;

    // Receiver FIFO stand-in: pops on a low strobe, head byte visible while non-empty.
    logic [7:0]  stim [0:4095];
    logic [11:0] wr_ptr = 12'd0;
    logic [11:0] rd_ptr = 12'd0;
    always @(negedge clk) begin
        if (kbd_ready && kbd_nextdata_n === 1'b0) rd_ptr = rd_ptr + 12'd1;
        kbd_ready = (rd_ptr != wr_ptr);
        kbd_data  = stim[rd_ptr];
    end

    // Reference model: set of held keys indexed by {ext,code}, plus prefix and Pause bookkeeping.
    logic [7:0] lc [0:25] = '{8'h1C,8'h32,8'h21,8'h23,8'h24,8'h2B,8'h34,8'h33,8'h43,8'h3B,8'h42,8'h4B,8'h3A,
                              8'h31,8'h44,8'h4D,8'h15,8'h2D,8'h1B,8'h2C,8'h3C,8'h2A,8'h1D,8'h22,8'h35,8'h1A};
    logic [7:0] dc [0:9]  = '{8'h45,8'h16,8'h1E,8'h26,8'h25,8'h2E,8'h36,8'h3D,8'h3E,8'h46};
    string      sym = ")!@#$%^&*(";
    bit         held [0:511];
    int         m_skip;
    bit         m_ext, m_brk, m_caps, last_v;
    logic [8:0] last_key;

    function automatic logic [7:0] ascii_ref(input logic [7:0] b, input bit sh, input bit up);
        for (int i = 0; i < 26; i++) if (lc[i] == b) return up ? 8'(65 + i) : 8'(97 + i);
        for (int i = 0; i < 10; i++) if (dc[i] == b) return sh ? sym[i] : 8'(48 + i);
        case (b)
            8'h29: return 8'h20;
            8'h5A: return 8'h0D;
            8'h66: return 8'h08;
            8'h0D: return 8'h09;
            8'h76: return 8'h1B;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 512; i++) held[i] = 1'b0;
        m_skip = 0; m_ext = 1'b0; m_brk = 1'b0; m_caps = 1'b0; last_v = 1'b0; last_key = 9'h000;
    endtask

    task automatic model_byte(input logic [7:0] b);
        logic [8:0] key;
        logic [7:0] asc;
        bit         sh, filtered;
        if (m_skip > 0) m_skip--;
        else if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else if (b == 8'hE1) begin m_skip = 7; m_ext = 1'b0; m_brk = 1'b0; end
        else begin
            key = {m_ext, b};
            sh = held[9'h012] | held[9'h059];
            filtered = 1'b0;
`ifdef KBD_REPEAT_FILTER_EN
            filtered = !m_brk && last_v && (last_key == key);
            if (!filtered) begin
                if (!m_brk) begin last_v = 1'b1; last_key = key; end
                else if (last_key == key) last_v = 1'b0;
            end
`endif
            if (!filtered) begin
                asc = (m_ext || m_brk) ? 8'h00 : ascii_ref(b, sh, sh ^ m_caps);
                if (key == 9'h058 && !m_brk && !held[key]) m_caps = !m_caps;
                held[key] = !m_brk;
                exp_q.push_back({b, m_ext, m_brk, asc, held[9'h012] | held[9'h059]});
            end
            m_ext = 1'b0; m_brk = 1'b0;
        end
    endtask

    task automatic push(input logic [7:0] b);
        stim[wr_ptr] = b;
        wr_ptr = wr_ptr + 12'd1;
        model_byte(b);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Records every event accepted during the window; optionally randomises ev_ready.
    task automatic collect(input int cycles, input bit rand_ready);
        for (int i = 0; i < cycles; i++) begin
            if (rand_ready) ev_ready = ($urandom_range(0, 3) != 0);
            if (ev_valid && ev_ready) got_q.push_back({ev_code, ev_ext, ev_break, ev_ascii, shift});
            tick();
        end
    endtask

    task automatic test_reset();
        repeat (3) tick();
        n_checks++;
        if ({kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift, ctrl, caps} !== 23'h400000) begin
            n_fail++;
            $display("FAIL reset_values: got %h want %h",
                     {kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift, ctrl, caps}, 23'h400000);
        end
        clrn = 1'b1;
        tick();
    endtask

    task automatic test_single_make();
        int t_rdy, t_pop, t_val, n_low;
        ev_t ev;
        t_rdy = -1; t_pop = -1; t_val = -1; n_low = 0; ev = '0;
        exp_q.delete();
        push(8'h1C);
        for (int t = 0; t < 20; t++) begin
            tick();
            if (kbd_ready && t_rdy < 0) t_rdy = t;
            if (!kbd_nextdata_n) begin n_low++; if (t_pop < 0) t_pop = t; end
            if (ev_valid && t_val < 0) begin t_val = t; ev = {ev_code, ev_ext, ev_break, ev_ascii, shift}; end
        end
        n_checks++;
        if (t_val - t_rdy != 3 || t_pop != t_rdy) begin
            n_fail++; $display("FAIL single_latency: ready %0d pop %0d valid %0d want pop=ready, valid=ready+3", t_rdy, t_pop, t_val);
        end
        n_checks++;
        if (n_low != 1) begin n_fail++; $display("FAIL single_pop_width: got %0d want 1", n_low); end
        n_checks++;
        if (ev !== ev_t'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b0})) begin
            n_fail++; $display("FAIL single_event: got %h want %h", ev, ev_t'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b0}));
        end
    endtask

    task automatic test_back_to_back();
        int times[$];
        exp_q.delete(); got_q.delete();
        push(8'h1C); push(8'h32); push(8'h21); push(8'h23);
        for (int t = 0; t < 40; t++) begin
            tick();
            if (ev_valid) begin times.push_back(t); got_q.push_back({ev_code, ev_ext, ev_break, ev_ascii, shift}); end
        end
        n_checks++;
        if (times.size() != 4) begin n_fail++; $display("FAIL b2b_count: got %0d want 4", times.size()); end
        for (int i = 1; i < times.size(); i++) begin
            n_checks++;
            if (times[i] - times[i-1] != 5) begin n_fail++; $display("FAIL b2b_spacing%0d: got %0d want 5", i, times[i] - times[i-1]); end
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL b2b_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_shift_letters();
        exp_q.delete(); got_q.delete();
        push(8'h12); push(8'h1C); push(8'hF0); push(8'h1C); push(8'hF0); push(8'h12);
        collect(50, 1'b0);
        n_checks++;
        if (got_q.size() != exp_q.size() || got_q.size() != 4) begin
            n_fail++; $display("FAIL shift_count: got %0d want 4 (model %0d)", got_q.size(), exp_q.size());
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL shift_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if (got_q.size() > 1 && got_q[1].ascii !== 8'h41) begin n_fail++; $display("FAIL shift_upper_a: got %h want 41", got_q[1].ascii); end
    endtask

    task automatic test_extended();
        exp_q.delete(); got_q.delete();
        push(8'hE0); push(8'h75); push(8'hE0); push(8'hF0); push(8'h75);
        collect(50, 1'b0);
        n_checks++;
        if (got_q.size() != 2) begin n_fail++; $display("FAIL ext_count: got %0d want 2", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL ext_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_pause();
        exp_q.delete(); got_q.delete();
        push(8'hE1);
        for (int i = 0; i < 7; i++) push(8'($urandom_range(0, 255)));
        push(8'h1C);
        collect(80, 1'b0);
        n_checks++;
        if (got_q.size() != 1 || got_q[0].code !== 8'h1C) begin
            n_fail++; $display("FAIL pause_skip: got %0d events first %h want 1 event code 1c", got_q.size(), got_q.size() > 0 ? got_q[0].code : 8'h00);
        end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL pause_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [19:0] snap;
        int          waited, unstable, popped;
        exp_q.delete(); got_q.delete();
        ev_ready = 1'b0;
        push(8'h2C); push(8'h24); push(8'h1B);
        waited = 0;
        while (!ev_valid && waited < 30) begin tick(); waited++; end
        n_checks++;
        if (!ev_valid) begin n_fail++; $display("FAIL bp_valid_timeout: got %b want 1", ev_valid); end
        snap = {ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift};
        unstable = 0; popped = 0;
        for (int t = 0; t < 15; t++) begin
            tick();
            if ({ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift} !== snap) unstable++;
            if (kbd_nextdata_n !== 1'b1) popped++;
        end
        n_checks++;
        if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: got %0d changed cycles want 0", unstable); end
        n_checks++;
        if (popped != 0 || wr_ptr - rd_ptr != 12'd2) begin
            n_fail++; $display("FAIL bp_no_pop: got %0d pops, %0d queued want 0 pops, 2 queued", popped, wr_ptr - rd_ptr);
        end
        ev_ready = 1'b1;
        collect(40, 1'b0);
        n_checks++;
        if (got_q.size() != 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL bp_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_repeat();
        int want;
        clrn = 1'b0; tick(); tick(); clrn = 1'b1; model_reset(); tick();
        exp_q.delete(); got_q.delete();
        push(8'h1C); push(8'h1C); push(8'h1C); push(8'hF0); push(8'h1C);
        collect(60, 1'b0);
`ifdef KBD_REPEAT_FILTER_EN
        want = 2;
`else
        want = 4;
`endif
        n_checks++;
        if (got_q.size() != want) begin n_fail++; $display("FAIL repeat_count: got %0d want %0d", got_q.size(), want); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL repeat_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        exp_q.delete(); got_q.delete();
        push(8'h58); push(8'h58); push(8'hF0); push(8'h58);
        collect(60, 1'b0);
        n_checks++;
        if (caps !== 1'b1 || caps !== m_caps) begin n_fail++; $display("FAIL caps_guard: got %b want 1 (model %b)", caps, m_caps); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL caps_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_random();
        logic [8:0] pool [0:11] = '{9'h01C,9'h032,9'h012,9'h059,9'h014,9'h114,9'h058,9'h029,9'h045,9'h016,9'h175,9'h05A};
        logic [8:0] k;
        int         nbytes;
        exp_q.delete(); got_q.delete();
        nbytes = 0;
        for (int n = 0; n < 80; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                push(8'hE1);
                for (int j = 0; j < 7; j++) push(8'($urandom_range(0, 255)));
                nbytes += 8;
            end
            k = pool[$urandom_range(0, 11)];
            if (k[8]) begin push(8'hE0); nbytes++; end
            if ($urandom_range(0, 2) == 0) begin push(8'hF0); nbytes++; end
            push(k[7:0]); nbytes++;
        end
        collect(nbytes * 12 + 50, 1'b1);
        ev_ready = 1'b1;
        collect(20, 1'b0);
        n_checks++;
        if (got_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_ev%0d: got %h want %h", i, got_q[i], exp_q[i]); end
        end
        n_checks++;
        if ({shift, ctrl, caps} !== {held[9'h012] | held[9'h059], held[9'h014] | held[9'h114], m_caps}) begin
            n_fail++; $display("FAIL rand_modifiers: got %b want %b", {shift, ctrl, caps},
                               {held[9'h012] | held[9'h059], held[9'h014] | held[9'h114], m_caps});
        end
    endtask

    task automatic test_reset_mid_prefix();
        exp_q.delete(); got_q.delete();
        push(8'hE0); push(8'hF0);
        collect(20, 1'b0);
        n_checks++;
        if (got_q.size() != 0) begin n_fail++; $display("FAIL prefix_no_event: got %0d want 0", got_q.size()); end
        clrn = 1'b0;
        tick(); tick();
        n_checks++;
        if ({kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift, ctrl, caps} !== 23'h400000) begin
            n_fail++; $display("FAIL midreset_values: got %h want %h",
                               {kbd_nextdata_n, ev_valid, ev_code, ev_ext, ev_break, ev_ascii, shift, ctrl, caps}, 23'h400000);
        end
        clrn = 1'b1;
        model_reset();
        tick();
        exp_q.delete();
        push(8'h1C);
        collect(20, 1'b0);
        n_checks++;
        if (got_q.size() != 1 || got_q[0] !== ev_t'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b0})) begin
            n_fail++; $display("FAIL midreset_fresh: got %0d events first %h want 1 event %h", got_q.size(),
                               got_q.size() > 0 ? got_q[0] : ev_t'(0), ev_t'({8'h1C, 1'b0, 1'b0, 8'h61, 1'b0}));
        end
    endtask

    initial begin
        clrn = 1'b0;
        ev_ready = 1'b1;
        model_reset();
        test_reset();
        test_single_make();
        test_back_to_back();
        test_shift_letters();
        test_extended();
        test_pause();
        test_backpressure();
        test_repeat();
        test_random();
        test_reset_mid_prefix();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
